// File: rtl/collision_scan.sv
// Sequential collision probe: checks the 16 cells of a 4x4 shape against the field, one per cycle.
// Optional macro COLLISION_SCAN_LR_EN enables left/right offsets; otherwise left/right act as in-place.
module collision_scan #(
  parameter int FIELD_W = 10,
  parameter int FIELD_H = 20,
  parameter int POS_W   = 5
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [1:0]                 dir,
  input  logic [FIELD_W*FIELD_H-1:0] field,
  input  logic [15:0]                block,
  input  logic [POS_W-1:0]           block_x,
  input  logic [POS_W-1:0]           block_y,
  output logic                       busy,
  output logic                       done,
  output logic                       collide,
  output logic [4:0]                 hit_count
);

  localparam int CW     = POS_W + 2;
  localparam int NCELLS = FIELD_W * FIELD_H;
  localparam int IDX_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state;
  logic [3:0]         k;
  logic [4:0]         cnt;
  logic [1:0]         dir_p0;
  logic [15:0]        blk_p0;
  logic [POS_W-1:0]   bx_p0;
  logic [POS_W-1:0]   by_p0;
  logic signed [CW-1:0] dx;
  logic signed [CW-1:0] dy;
  logic signed [CW-1:0] tx;
  logic signed [CW-1:0] ty;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               hit;
  logic [4:0]         cnt_nxt;

  function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic inc);
    if (inc && (v < 5'd16)) return v + 5'd1;
    return v;
  endfunction

  // Operand capture: the move request is frozen at acceptance; field stays live.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && start) begin
      dir_p0 <= dir;
      blk_p0 <= block;
      bx_p0  <= block_x;
      by_p0  <= block_y;
    end
  end

  // Target-cell evaluation for cell k; ty is never negative since dy is 0 or +1.
  always_comb begin
    dx = '0;
    dy = '0;
    case (dir_p0)
      2'b00: dy = {{(CW-1){1'b0}}, 1'b1};
`ifdef COLLISION_SCAN_LR_EN
      2'b01: dx = '1;
      2'b10: dx = {{(CW-1){1'b0}}, 1'b1};
`endif
      default: ;
    endcase
    tx = $signed({2'b00, bx_p0}) + $signed({{(CW-2){1'b0}}, k[1:0]}) + dx;
    ty = $signed({2'b00, by_p0}) + $signed({{(CW-2){1'b0}}, k[3:2]}) + dy;
    in_range = !tx[CW-1] && (int'(tx) < FIELD_W) && (int'(ty) < FIELD_H);
    idx = '0;
    if (in_range) idx = IDX_W'(int'(ty) * FIELD_W + int'(tx));
    hit = blk_p0[k] && (!in_range || field[idx]);
    cnt_nxt = sat_inc(cnt, hit);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      k         <= 4'd0;
      cnt       <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      collide   <= 1'b0;
      hit_count <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SCAN;
            k     <= 4'd0;
            cnt   <= 5'd0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          cnt <= cnt_nxt;
          k   <= k + 4'd1;
          if (k == 4'd15) begin
            state     <= DONE;
            done      <= 1'b1;
            collide   <= (cnt_nxt != 5'd0);
            hit_count <= cnt_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scan.sv
// Directed self-checking bench for collision_scan with hand-computed expectations.
module tb_collision_scan;
  localparam int FW = 10;
  localparam int FH = 20;
  localparam int NC = FW * FH;

  logic          clock;
  logic          resetn;
  logic          start;
  logic [1:0]    dir;
  logic [NC-1:0] field;
  logic [15:0]   block;
  logic [4:0]    block_x;
  logic [4:0]    block_y;
  logic          busy;
  logic          done;
  logic          collide;
  logic [4:0]    hit_count;

  int n_cmp = 0;
  int n_fail = 0;

  collision_scan #(.FIELD_W(FW), .FIELD_H(FH), .POS_W(5)) dut (
    .clock(clock), .resetn(resetn), .start(start), .dir(dir), .field(field),
    .block(block), .block_x(block_x), .block_y(block_y), .busy(busy),
    .done(done), .collide(collide), .hit_count(hit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clock);
  endtask

  // Issues one request and returns latency (-1 on timeout) and the result seen with done.
  task automatic do_scan(input logic [1:0] d, input logic [NC-1:0] f, input logic [15:0] b,
                         input logic [4:0] x, input logic [4:0] y,
                         output int lat, output logic c, output logic [4:0] h);
    wait_idle();
    @(negedge clock);
    dir = d; field = f; block = b; block_x = x; block_y = y; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = -1; c = 1'bx; h = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        lat = i; c = collide; h = hit_count;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (collide !== 1'b0) begin n_fail++; $display("FAIL reset_collide: got %b want 0", collide); end
    n_cmp++; if (hit_count !== 5'd0) begin n_fail++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
    resetn = 1'b1;
  endtask

  task automatic test_down_clear();
    int lat; logic c; logic [4:0] h;
    do_scan(2'b00, '0, 16'h0660, 5'd3, 5'd0, lat, c, h);
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL clear_latency: got %0d want 17", lat); end
    n_cmp++; if (c !== 1'b0) begin n_fail++; $display("FAIL clear_collide: got %b want 0", c); end
    n_cmp++; if (h !== 5'd0) begin n_fail++; $display("FAIL clear_hits: got %0d want 0", h); end
  endtask

  task automatic test_floor();
    int lat; logic c; logic [4:0] h;
    do_scan(2'b00, '0, 16'h0660, 5'd3, 5'd17, lat, c, h);
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL floor_latency: got %0d want 17", lat); end
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL floor_collide: got %b want 1", c); end
    n_cmp++; if (h !== 5'd2) begin n_fail++; $display("FAIL floor_hits: got %0d want 2", h); end
  endtask

  task automatic test_left_wall();
    int lat; logic c; logic [4:0] h; logic ec; logic [4:0] eh;
`ifdef COLLISION_SCAN_LR_EN
    ec = 1'b1; eh = 5'd1;
`else
    ec = 1'b0; eh = 5'd0;
`endif
    do_scan(2'b01, '0, 16'h000F, 5'd0, 5'd5, lat, c, h);
    n_cmp++; if (c !== ec) begin n_fail++; $display("FAIL left_collide: got %b want %b", c, ec); end
    n_cmp++; if (h !== eh) begin n_fail++; $display("FAIL left_hits: got %0d want %0d", h, eh); end
  endtask

  task automatic test_field_hit();
    int lat; logic c; logic [4:0] h; logic [NC-1:0] f;
    f = '0; f[10*FW+4] = 1'b1;
    do_scan(2'b00, f, 16'h0001, 5'd4, 5'd9, lat, c, h);
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL field_down_collide: got %b want 1", c); end
    n_cmp++; if (h !== 5'd1) begin n_fail++; $display("FAIL field_down_hits: got %0d want 1", h); end
    do_scan(2'b10, f, 16'h0001, 5'd4, 5'd9, lat, c, h);
    n_cmp++; if (c !== 1'b0) begin n_fail++; $display("FAIL field_right_collide: got %b want 0", c); end
    n_cmp++; if (h !== 5'd0) begin n_fail++; $display("FAIL field_right_hits: got %0d want 0", h); end
  endtask

  task automatic test_inplace();
    int lat; logic c; logic [4:0] h; logic [NC-1:0] f;
    f = '0; f[10*FW+4] = 1'b1;
    do_scan(2'b11, f, 16'h0001, 5'd4, 5'd10, lat, c, h);
    n_cmp++; if (h !== 5'd1) begin n_fail++; $display("FAIL inplace_overlap_hits: got %0d want 1", h); end
    f = '0; f[5:2] = 4'hF;
    do_scan(2'b11, f, 16'h000F, 5'd2, 5'd0, lat, c, h);
    n_cmp++; if (h !== 5'd4) begin n_fail++; $display("FAIL inplace_row_hits: got %0d want 4", h); end
    do_scan(2'b11, '0, 16'h000F, 5'd7, 5'd3, lat, c, h);
    n_cmp++; if (h !== 5'd1) begin n_fail++; $display("FAIL right_edge_hits: got %0d want 1", h); end
  endtask

  task automatic test_empty_and_full();
    int lat; logic c; logic [4:0] h;
    do_scan(2'b00, '1, 16'h0000, 5'd31, 5'd31, lat, c, h);
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL empty_latency: got %0d want 17", lat); end
    n_cmp++; if ({c, h} !== 6'd0) begin n_fail++; $display("FAIL empty_result: got c=%b h=%0d want 0/0", c, h); end
    do_scan(2'b00, '0, 16'hFFFF, 5'd31, 5'd31, lat, c, h);
    n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL full_collide: got %b want 1", c); end
    n_cmp++; if (h !== 5'd16) begin n_fail++; $display("FAIL full_hits: got %0d want 16", h); end
  endtask

  task automatic test_reset_abort();
    int lat; logic c; logic [4:0] h; logic saw;
    wait_idle();
    @(negedge clock);
    dir = 2'b00; field = '0; block = 16'h0660; block_x = 5'd3; block_y = 5'd17; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (8) @(negedge clock);
    resetn = 1'b0;
    #1;
    n_cmp++; if ({busy, done, collide, hit_count} !== 8'd0) begin
      n_fail++; $display("FAIL abort_outputs: got b=%b d=%b c=%b h=%0d want all 0", busy, done, collide, hit_count);
    end
    saw = 1'b0;
    repeat (2) @(negedge clock) if (done) saw = 1'b1;
    resetn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (done) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", saw); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    do_scan(2'b00, '0, 16'h0660, 5'd3, 5'd17, lat, c, h);
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d want 17", lat); end
    n_cmp++; if ({c, h} !== {1'b1, 5'd2}) begin n_fail++; $display("FAIL abort_rerun_result: got c=%b h=%0d want 1/2", c, h); end
  endtask

  task automatic test_back_to_back();
    int ndone; int nlow; int bad_pos; int bad_val;
    ndone = 0; nlow = 0; bad_pos = 0; bad_val = 0;
    wait_idle();
    @(negedge clock);
    dir = 2'b00; field = '0; block = 16'h0660; block_x = 5'd3; block_y = 5'd17; start = 1'b1;
    for (int i = 1; i <= 53; i++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        if (i != 17 && i != 35 && i != 53) bad_pos++;
        if (collide !== 1'b1 || hit_count !== 5'd2) bad_val++;
      end
      if (!busy) nlow++;
    end
    start = 1'b0;
    n_cmp++; if (ndone !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", ndone); end
    n_cmp++; if (bad_pos !== 0) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d misplaced want 0", bad_pos); end
    n_cmp++; if (nlow !== 2) begin n_fail++; $display("FAIL b2b_idle_cycles: got %0d want 2", nlow); end
    n_cmp++; if (bad_val !== 0) begin n_fail++; $display("FAIL b2b_results: got %0d wrong want 0", bad_val); end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; dir = 2'b00; field = '0; block = '0;
    block_x = '0; block_y = '0;
    test_reset();
    test_down_clear();
    test_floor();
    test_left_wall();
    test_field_hit();
    test_inplace();
    test_empty_and_full();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
